// File: rtl/err_scan_ctrl.sv
// Background scanner for a bank of sticky error registers, with host access arbitration.
// Summarises nonzero registers into err_summary and raises a level interrupt.
module err_scan_ctrl #(
  parameter int unsigned              REG_NUM    = 8,
  parameter int unsigned              ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = ADDR_WIDTH'('h100),
  parameter int unsigned              SCAN_GAP   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_req,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [31:0]           host_wdata,
  output logic                  host_ack,
  output logic [31:0]           host_rdata,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr,
  output logic [31:0]           reg_wdata,
  input  logic [31:0]           reg_rdata,
  input  logic                  irq_en,
  output logic [REG_NUM-1:0]    err_summary,
  output logic                  irq
);

  localparam int unsigned       IDX_W    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int unsigned       GAP_W    = 16;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(REG_NUM - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(SCAN_GAP);
  localparam bit                ZERO_GAP = (SCAN_GAP == 0);

  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOST = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  state_e                  ret_q, ret_d;
  state_e                  resume_state;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
  logic                    reg_wr_q, reg_wr_d;
  logic [31:0]             reg_wdata_q, reg_wdata_d;
  logic                    host_ack_q, host_ack_d;
  logic [31:0]             host_rdata_q, host_rdata_d;
  logic [REG_NUM-1:0]      err_q, err_d;
  logic                    irq_q, irq_d;

  // State register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_GAP;
      ret_q        <= ST_GAP;
      idx_q        <= '0;
      gap_q        <= GAP_LOAD;
      reg_addr_q   <= '0;
      reg_wr_q     <= 1'b0;
      reg_wdata_q  <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      err_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      reg_addr_q   <= reg_addr_d;
      reg_wr_q     <= reg_wr_d;
      reg_wdata_q  <= reg_wdata_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      err_q        <= err_d;
      irq_q        <= irq_d;
    end
  end

  // Next state; bus outputs are decoded from the next state so they are registered
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    resume_state = ST_SCAN;
    reg_addr_d   = '0;
    reg_wr_d     = 1'b0;
    reg_wdata_d  = '0;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    err_d        = err_q;
    irq_d        = irq_en & (|err_q);

    case (state_q)
      ST_GAP: begin
        // A host request freezes the gap counter until the access completes
        if (host_req) begin
          state_d = ST_HOST;
          ret_d   = ST_GAP;
        end else if (gap_q <= GAP_W'(1)) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ST_SCAN: begin
        err_d[idx_q] = |reg_rdata;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (ZERO_GAP) begin
            resume_state = ST_SCAN;
          end else begin
            resume_state = ST_GAP;
            gap_d        = GAP_LOAD;
          end
        end else begin
          idx_d        = idx_q + IDX_W'(1);
          resume_state = ST_SCAN;
        end
        if (host_req) begin
          state_d = ST_HOST;
          ret_d   = resume_state;
        end else begin
          state_d = resume_state;
        end
      end
      ST_HOST: begin
        host_rdata_d = reg_rdata;
        state_d      = ST_ACK;
      end
      ST_ACK: begin
        state_d = ret_q;
      end
      default: begin
        state_d = ST_GAP;
      end
    endcase

    case (state_d)
      ST_SCAN: begin
        reg_addr_d = BASE_ADDR + ADDR_WIDTH'(idx_d);
      end
      ST_HOST: begin
        reg_addr_d  = host_addr;
        reg_wr_d    = host_wr;
        reg_wdata_d = host_wdata;
      end
      ST_ACK: begin
        host_ack_d = 1'b1;
      end
      default: begin
        reg_addr_d = '0;
      end
    endcase
  end

  assign host_ack    = host_ack_q;
  assign host_rdata  = host_rdata_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wdata   = reg_wdata_q;
  assign err_summary = err_q;
  assign irq         = irq_q;

endmodule
